bsg_mcl_host_slot_bridge: RTL and testbench
===========================================

BSG_MCL_HOST_SLOT_BRIDGE -- requirements
Module: bsg_mcl_host_slot_bridge

Interface
REQ-001 SHALL have parameter num_slots_p, default 2, number of independent host slots.
REQ-002 SHALL have parameter host_width_p, default 32, host word width in bits.
REQ-003 SHALL have parameter pkt_width_p, default 128, packet width in bits; it must be an integer multiple (>=2) of host_width_p.
REQ-004 SHALL have parameter rcv_els_p, default 64, per-slot receive FIFO depth in packets.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports host_v_i / host_data_i / host_ready_o, in/in/out, [num_slots_p] / [num_slots_p][host_width_p] / [num_slots_p], host-to-bridge words.
REQ-008 SHALL have ports pkt_v_o / pkt_data_o / pkt_ready_i, out/out/in, [num_slots_p] / [num_slots_p][pkt_width_p] / [num_slots_p], assembled packets to endpoint.
REQ-009 SHALL have ports pkt_v_i / pkt_data_i / pkt_ready_o, in/in/out, same widths, packets from endpoint.
REQ-010 SHALL have ports host_v_o / host_data_o / host_yumi_i, out/out/in, [num_slots_p] / [num_slots_p][host_width_p] / [num_slots_p], bridge-to-host words.
REQ-011 SHALL have port flush_i, input, [num_slots_p], per-slot synchronous flush.
REQ-012 SHALL have port rcv_vacancy_o, output, [num_slots_p][32], free receive FIFO entries, zero-extended.

Function
REQ-013 Slots SHALL be fully independent; no slot may stall on another.
REQ-014 TX: a word SHALL be accepted when host_v_i & host_ready_o; host_ready_o = (word count < words_per_pkt) & ~flush_i.
REQ-015 TX: the k-th accepted word SHALL land in pkt bits [k*host_width_p +: host_width_p] (LSW first).
REQ-016 TX: pkt_v_o SHALL assert the cycle after the last word is accepted and hold, with stable data, until pkt_ready_i.
REQ-017 TX: on pkt_v_o & pkt_ready_i the count SHALL clear; host_ready_o SHALL be 0 in that cycle (no same-cycle refill).
REQ-018 RX: pkt_ready_o SHALL equal receive FIFO not full & ~flush_i; the FIFO SHALL be ready-then-valid safe (valid may depend on ready).
REQ-019 RX: host_v_o SHALL equal FIFO non-empty; host_data_o SHALL present head-packet word index w, LSW first.
REQ-020 RX: host_yumi_i SHALL only be asserted with host_v_o; each yumi SHALL advance w; yumi at w = words_per_pkt-1 SHALL dequeue the head and reset w to 0.
REQ-021 Vacancy SHALL decrement on enqueue, increment on dequeue, stay unchanged on both in one cycle, and stay within [0, rcv_els_p].
REQ-022 Full FIFO: pkt_ready_o = 0 and vacancy = 0; a simultaneous final-word dequeue SHALL NOT raise pkt_ready_o in that same cycle.
REQ-023 flush_i[i] SHALL, in one cycle, discard slot i's partial TX assembly, any pending pkt_v_o, all receive FIFO contents and w; the next cycle shows count = 0, pkt_v_o = 0, host_v_o = 0, vacancy = rcv_els_p.
REQ-024 flush_i SHALL take priority over any coincident handshake on that slot; that handshake SHALL NOT take effect.

Reset
REQ-025 During and after reset_i, outputs SHALL be: host_ready_o = 1, pkt_v_o = 0, pkt_ready_o = 1, host_v_o = 0, rcv_vacancy_o = rcv_els_p, all counts and w = 0.
REQ-026 Reset asserted mid-packet SHALL discard all partial and buffered data identically to a flush of every slot.

Structure
REQ-027 words_per_pkt (pkt_width_p/host_width_p) and its counter width SHALL be derived constants in the shared package bsg_mcl_bridge_pkg.
REQ-028 Per-slot logic SHALL live in one sub-module bsg_mcl_host_slot, generated num_slots_p times.
REQ-029 The receive buffer SHALL be bsg_fifo_1r1w_small; no other external state.

Verification
REQ-030 Slot 0 TX words 0x11111111, 0x22222222, 0x33333333, 0x44444444 back to back -> pkt_data_o = 0x44444444_33333333_22222222_11111111, pkt_v_o one cycle after 4th word.
REQ-031 pkt_ready_i held 0 for 10 cycles after assembly -> pkt_v_o and data stable; host_ready_o = 0 throughout.
REQ-032 Inject 64 RX packets with host_yumi_i = 0 (rcv_els_p = 64) -> vacancy 64 -> 0, pkt_ready_o = 0; then one final-word yumi with a new pkt_v_i -> vacancy 1 next cycle, new packet not accepted that cycle.
REQ-033 2 words accepted, then flush_i[0] alongside 3rd word -> word dropped, next packet assembles from fresh words only; slot 1 traffic unaffected.
REQ-034 Random host/endpoint traffic on both slots with random stalls for 10000 cycles -> scoreboard shows in-order, lossless data per slot; vacancy equals rcv_els_p minus FIFO occupancy every cycle.
REQ-035 reset_i asserted for 1 cycle mid-RX-serialization (w = 2) -> all outputs return to REQ-025 values the next cycle.

Source files
------------

// File: rtl/bsg_mcl_bridge_pkg.sv
// Shared constants and sizing helpers for the host/endpoint slot bridge.
// Every module derives its word counts from the same functions, so the sizes always agree.
package bsg_mcl_bridge_pkg;

    localparam int host_width_gp = 32;
    localparam int pkt_width_gp  = 128;

    function automatic int words_per_pkt(input int pkt_width, input int host_width);
        return pkt_width / host_width;
    endfunction

    // The assembly counter must be able to hold the value words, not just words-1.
    function automatic int word_cnt_width(input int words);
        return $clog2(words + 1);
    endfunction

    function automatic int word_idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small single-clock FIFO with a valid/ready input side and a valid/yumi output side.
// ready_o depends only on state, so an upstream valid may safely depend on it.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 128,
    parameter int els_p   = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [width_p-1:0]         data_i,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    enq, deq;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    assign ready_o = (count_q != cnt_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path can infer a latch.
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        // NOTE: blocking assignments here build the next-state value; only always_ff uses <=.
        if (enq) wptr_d = ptr_inc(wptr_q);
        if (deq) rptr_d = ptr_inc(rptr_q);
        if (enq && !deq)      count_d = count_q + cnt_width_lp'(1);
        else if (deq && !enq) count_d = count_q - cnt_width_lp'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bsg_mcl_host_slot.sv
// One independent bridge slot: host words are assembled LSW-first into a packet (TX),
// and endpoint packets are buffered and serialized back to the host LSW-first (RX).
module bsg_mcl_host_slot
    import bsg_mcl_bridge_pkg::*;
#(
    parameter int host_width_p = host_width_gp,
    parameter int pkt_width_p  = pkt_width_gp,
    parameter int rcv_els_p    = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,

    input  logic                    host_v_i,
    input  logic [host_width_p-1:0] host_data_i,
    output logic                    host_ready_o,

    output logic                    pkt_v_o,
    output logic [pkt_width_p-1:0]  pkt_data_o,
    input  logic                    pkt_ready_i,

    input  logic                    pkt_v_i,
    input  logic [pkt_width_p-1:0]  pkt_data_i,
    output logic                    pkt_ready_o,

    output logic                    host_v_o,
    output logic [host_width_p-1:0] host_data_o,
    input  logic                    host_yumi_i,

    output logic [31:0]             rcv_vacancy_o
);

    localparam int words_lp          = words_per_pkt(pkt_width_p, host_width_p);
    localparam int cnt_width_lp      = word_cnt_width(words_lp);
    localparam int idx_width_lp      = word_idx_width(words_lp);
    localparam int fifo_cnt_width_lp = $clog2(rcv_els_p + 1);

    logic [cnt_width_lp-1:0] tx_cnt_q, tx_cnt_d;
    logic [pkt_width_p-1:0]  tx_data_q, tx_data_d;
    logic                    tx_full, host_acc, pkt_sent;

    // A full count means the packet is on pkt_v_o; refill waits until the cycle after it leaves.
    assign tx_full      = (tx_cnt_q == cnt_width_lp'(words_lp));
    assign host_ready_o = reset_i | (~tx_full & ~flush_i);
    assign pkt_v_o      = ~reset_i & tx_full;
    assign pkt_data_o   = tx_data_q;
    assign host_acc     = host_v_i & host_ready_o;
    assign pkt_sent     = pkt_v_o & pkt_ready_i;

    always_comb begin
        tx_cnt_d  = tx_cnt_q;
        tx_data_d = tx_data_q;
        if (host_acc) begin
            tx_data_d[tx_cnt_q*host_width_p +: host_width_p] = host_data_i;
            tx_cnt_d = tx_cnt_q + cnt_width_lp'(1);
        end
        if (pkt_sent || flush_i) tx_cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) tx_cnt_q <= '0;
        else         tx_cnt_q <= tx_cnt_d;
    end

    always_ff @(posedge clk_i) begin
        tx_data_q <= tx_data_d;
    end

    logic                         fifo_reset, fifo_ready, fifo_v, fifo_yumi;
    logic                         rx_adv, rx_last;
    logic [pkt_width_p-1:0]       fifo_data;
    logic [fifo_cnt_width_lp-1:0] fifo_count;
    logic [idx_width_lp-1:0]      rx_w_q, rx_w_d;

    // Flush empties the buffer through its own reset, which also blocks any coincident enqueue.
    assign fifo_reset  = reset_i | flush_i;
    assign pkt_ready_o = reset_i | (fifo_ready & ~flush_i);
    assign host_v_o    = ~reset_i & fifo_v;
    assign host_data_o = fifo_data[rx_w_q*host_width_p +: host_width_p];
    assign rx_adv      = host_yumi_i & fifo_v;
    assign rx_last     = (rx_w_q == idx_width_lp'(words_lp - 1));
    assign fifo_yumi   = rx_adv & rx_last & ~flush_i;

    always_comb begin
        rx_w_d = rx_w_q;
        if (rx_adv) rx_w_d = rx_last ? '0 : rx_w_q + idx_width_lp'(1);
        if (flush_i) rx_w_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) rx_w_q <= '0;
        else         rx_w_q <= rx_w_d;
    end

    bsg_fifo_1r1w_small #(
        .width_p (pkt_width_p),
        .els_p   (rcv_els_p)
    ) rcv_fifo (
        .clk_i   (clk_i),
        .reset_i (fifo_reset),
        .v_i     (pkt_v_i),
        .ready_o (fifo_ready),
        .data_i  (pkt_data_i),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (fifo_yumi),
        .count_o (fifo_count)
    );

    assign rcv_vacancy_o = reset_i ? 32'(rcv_els_p) : 32'(rcv_els_p) - 32'(fifo_count);

endmodule

// File: rtl/bsg_mcl_host_slot_bridge.sv
// Multi-slot host bridge: num_slots_p fully independent copies of bsg_mcl_host_slot.
module bsg_mcl_host_slot_bridge
    import bsg_mcl_bridge_pkg::*;
#(
    parameter int num_slots_p  = 2,
    parameter int host_width_p = host_width_gp,
    parameter int pkt_width_p  = pkt_width_gp,
    parameter int rcv_els_p    = 64
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,

    input  logic [num_slots_p-1:0]                   host_v_i,
    input  logic [num_slots_p-1:0][host_width_p-1:0] host_data_i,
    output logic [num_slots_p-1:0]                   host_ready_o,

    output logic [num_slots_p-1:0]                   pkt_v_o,
    output logic [num_slots_p-1:0][pkt_width_p-1:0]  pkt_data_o,
    input  logic [num_slots_p-1:0]                   pkt_ready_i,

    input  logic [num_slots_p-1:0]                   pkt_v_i,
    input  logic [num_slots_p-1:0][pkt_width_p-1:0]  pkt_data_i,
    output logic [num_slots_p-1:0]                   pkt_ready_o,

    output logic [num_slots_p-1:0]                   host_v_o,
    output logic [num_slots_p-1:0][host_width_p-1:0] host_data_o,
    input  logic [num_slots_p-1:0]                   host_yumi_i,

    input  logic [num_slots_p-1:0]                   flush_i,
    output logic [num_slots_p-1:0][31:0]             rcv_vacancy_o
);

    for (genvar i = 0; i < num_slots_p; i++) begin : slot
        bsg_mcl_host_slot #(
            .host_width_p (host_width_p),
            .pkt_width_p  (pkt_width_p),
            .rcv_els_p    (rcv_els_p)
        ) slot_inst (
            .clk_i         (clk_i),
            .reset_i       (reset_i),
            .flush_i       (flush_i[i]),
            .host_v_i      (host_v_i[i]),
            .host_data_i   (host_data_i[i]),
            .host_ready_o  (host_ready_o[i]),
            .pkt_v_o       (pkt_v_o[i]),
            .pkt_data_o    (pkt_data_o[i]),
            .pkt_ready_i   (pkt_ready_i[i]),
            .pkt_v_i       (pkt_v_i[i]),
            .pkt_data_i    (pkt_data_i[i]),
            .pkt_ready_o   (pkt_ready_o[i]),
            .host_v_o      (host_v_o[i]),
            .host_data_o   (host_data_o[i]),
            .host_yumi_i   (host_yumi_i[i]),
            .rcv_vacancy_o (rcv_vacancy_o[i])
        );
    end

endmodule

// File: tb/tb_bsg_mcl_host_slot_bridge.sv
// Self-checking bench: directed vector table and corner sequences, then randomized
// two-slot traffic compared against a queue-based reference model.
module tb_bsg_mcl_host_slot_bridge;

    localparam int NS  = 2;
    localparam int HW  = 32;
    localparam int PW  = 128;
    localparam int ELS = 64;
    localparam int WPP = PW / HW;

    logic                   clk = 1'b0;
    logic                   reset_i;
    logic [NS-1:0]          host_v_i, host_ready_o;
    logic [NS-1:0][HW-1:0]  host_data_i;
    logic [NS-1:0]          pkt_v_o, pkt_ready_i;
    logic [NS-1:0][PW-1:0]  pkt_data_o;
    logic [NS-1:0]          pkt_v_i, pkt_ready_o;
    logic [NS-1:0][PW-1:0]  pkt_data_i;
    logic [NS-1:0]          host_v_o, host_yumi_i;
    logic [NS-1:0][HW-1:0]  host_data_o;
    logic [NS-1:0]          flush_i;
    logic [NS-1:0][31:0]    rcv_vacancy_o;

    always #5 clk = ~clk;

    bsg_mcl_host_slot_bridge #(
        .num_slots_p  (NS),
        .host_width_p (HW),
        .pkt_width_p  (PW),
        .rcv_els_p    (ELS)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .host_v_i      (host_v_i),
        .host_data_i   (host_data_i),
        .host_ready_o  (host_ready_o),
        .pkt_v_o       (pkt_v_o),
        .pkt_data_o    (pkt_data_o),
        .pkt_ready_i   (pkt_ready_i),
        .pkt_v_i       (pkt_v_i),
        .pkt_data_i    (pkt_data_i),
        .pkt_ready_o   (pkt_ready_o),
        .host_v_o      (host_v_o),
        .host_data_o   (host_data_o),
        .host_yumi_i   (host_yumi_i),
        .flush_i       (flush_i),
        .rcv_vacancy_o (rcv_vacancy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        host_v_i    = '0;
        host_data_i = '0;
        pkt_ready_i = '0;
        pkt_v_i     = '0;
        pkt_data_i  = '0;
        host_yumi_i = '0;
        flush_i     = '0;
    endtask

    // ---------------- reference model ----------------
    logic [HW-1:0] m_tx_words [NS][$];
    bit            m_tx_pend  [NS];
    logic [PW-1:0] m_tx_pkt   [NS];
    logic [PW-1:0] m_rxq      [NS][$];
    int            m_rx_w     [NS];

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            m_tx_words[s].delete();
            m_tx_pend[s] = 1'b0;
            m_tx_pkt[s]  = '0;
            m_rxq[s].delete();
            m_rx_w[s]    = 0;
        end
    endtask

    function automatic logic [PW-1:0] pack_tx(input int s);
        logic [PW-1:0] p = '0;
        for (int k = 0; k < WPP; k++) p[k*HW +: HW] = m_tx_words[s][k];
        return p;
    endfunction

    function automatic logic [PW-1:0] rx_pkt(input int i);
        logic [PW-1:0] p = '0;
        for (int k = 0; k < WPP; k++) p[k*HW +: HW] = 32'hBE00_0000 | (32'(i) << 8) | 32'(k);
        return p;
    endfunction

    function automatic logic [HW-1:0] word_of(input logic [PW-1:0] p, input int k);
        return p[k*HW +: HW];
    endfunction

    task automatic do_reset();
        idle_inputs();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        model_clear();
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int s = 0; s < NS; s++) begin
            check($sformatf("%s host_ready[%0d]", tag, s), PW'(host_ready_o[s]), PW'(1));
            check($sformatf("%s pkt_v[%0d]", tag, s), PW'(pkt_v_o[s]), PW'(0));
            check($sformatf("%s pkt_ready[%0d]", tag, s), PW'(pkt_ready_o[s]), PW'(1));
            check($sformatf("%s host_v[%0d]", tag, s), PW'(host_v_o[s]), PW'(0));
            check($sformatf("%s vacancy[%0d]", tag, s), PW'(rcv_vacancy_o[s]), PW'(ELS));
        end
    endtask

    // One randomized cycle: drive, compare against model, advance model, clock.
    task automatic rand_cycle(input int cyc);
        bit slow_drain = ((cyc / 700) % 2) == 1;
        bit exp_hr, exp_pr, exp_hv;
        for (int s = 0; s < NS; s++) begin
            host_v_i[s]    = ($urandom % 4) != 0;
            host_data_i[s] = $urandom;
            pkt_ready_i[s] = ($urandom % 3) != 0;
            pkt_v_i[s]     = slow_drain ? (($urandom % 2) == 0) : (($urandom % 8) == 0);
            pkt_data_i[s]  = {$urandom, $urandom, $urandom, $urandom};
            host_yumi_i[s] = (m_rxq[s].size() > 0) &&
                             (slow_drain ? (($urandom % 8) == 0) : (($urandom % 4) != 0));
            flush_i[s]     = ($urandom % 300) == 0;
        end
        settle();
        for (int s = 0; s < NS; s++) begin
            exp_hr = !m_tx_pend[s] && !flush_i[s];
            exp_pr = (m_rxq[s].size() < ELS) && !flush_i[s];
            exp_hv = m_rxq[s].size() > 0;
            check($sformatf("rand host_ready[%0d]", s), PW'(host_ready_o[s]), PW'(exp_hr));
            check($sformatf("rand pkt_v[%0d]", s), PW'(pkt_v_o[s]), PW'(m_tx_pend[s]));
            if (m_tx_pend[s]) check($sformatf("rand pkt_data[%0d]", s), pkt_data_o[s], m_tx_pkt[s]);
            check($sformatf("rand pkt_ready[%0d]", s), PW'(pkt_ready_o[s]), PW'(exp_pr));
            check($sformatf("rand host_v[%0d]", s), PW'(host_v_o[s]), PW'(exp_hv));
            if (exp_hv) check($sformatf("rand host_data[%0d]", s), PW'(host_data_o[s]),
                              PW'(word_of(m_rxq[s][0], m_rx_w[s])));
            check($sformatf("rand vacancy[%0d]", s), PW'(rcv_vacancy_o[s]),
                  PW'(ELS - m_rxq[s].size()));

            if (flush_i[s]) begin
                m_tx_words[s].delete();
                m_tx_pend[s] = 1'b0;
                m_rxq[s].delete();
                m_rx_w[s] = 0;
            end else begin
                if (m_tx_pend[s] && pkt_ready_i[s]) m_tx_pend[s] = 1'b0;
                if (host_v_i[s] && exp_hr) begin
                    m_tx_words[s].push_back(host_data_i[s]);
                    if (m_tx_words[s].size() == WPP) begin
                        m_tx_pkt[s]  = pack_tx(s);
                        m_tx_pend[s] = 1'b1;
                        m_tx_words[s].delete();
                    end
                end
                if (host_yumi_i[s] && exp_hv) begin
                    if (m_rx_w[s] == WPP - 1) begin
                        void'(m_rxq[s].pop_front());
                        m_rx_w[s] = 0;
                    end else begin
                        m_rx_w[s]++;
                    end
                end
                if (pkt_v_i[s] && exp_pr) m_rxq[s].push_back(pkt_data_i[s]);
            end
        end
        tick();
    endtask

    typedef struct {
        logic          hv;
        logic [HW-1:0] hd;
        logic          pr;
        logic          e_hr;
        logic          e_pv;
        logic [PW-1:0] e_pd;
    } tx_vec_t;

    tx_vec_t vecs [7];

    initial begin
        logic [PW-1:0] exp_pkt;

        vecs[0] = '{1'b1, 32'h1111_1111, 1'b0, 1'b1, 1'b0, '0};
        vecs[1] = '{1'b1, 32'h2222_2222, 1'b0, 1'b1, 1'b0, '0};
        vecs[2] = '{1'b1, 32'h3333_3333, 1'b0, 1'b1, 1'b0, '0};
        vecs[3] = '{1'b1, 32'h4444_4444, 1'b0, 1'b1, 1'b0, '0};
        vecs[4] = '{1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 128'h44444444_33333333_22222222_11111111};
        vecs[5] = '{1'b1, 32'h6666_6666, 1'b1, 1'b0, 1'b1, 128'h44444444_33333333_22222222_11111111};
        vecs[6] = '{1'b1, 32'h7777_7777, 1'b0, 1'b1, 1'b0, '0};

        idle_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        model_clear();
        settle();
        check_reset_outputs("reset");

        // Table: four-word assembly, hold, handshake without same-cycle refill.
        for (int i = 0; i < 7; i++) begin
            host_v_i[0]    = vecs[i].hv;
            host_data_i[0] = vecs[i].hd;
            pkt_ready_i[0] = vecs[i].pr;
            settle();
            check($sformatf("vec%0d host_ready", i), PW'(host_ready_o[0]), PW'(vecs[i].e_hr));
            check($sformatf("vec%0d pkt_v", i), PW'(pkt_v_o[0]), PW'(vecs[i].e_pv));
            if (vecs[i].e_pv) check($sformatf("vec%0d pkt_data", i), pkt_data_o[0], vecs[i].e_pd);
            tick();
        end

        // Backpressure: packet and data hold for 10 cycles, host_ready stays low.
        do_reset();
        exp_pkt = '0;
        for (int k = 0; k < WPP; k++) begin
            host_v_i[0]    = 1'b1;
            host_data_i[0] = 32'hA000_0000 + 32'(k);
            exp_pkt[k*HW +: HW] = 32'hA000_0000 + 32'(k);
            tick();
        end
        host_data_i[0] = 32'hDEAD_BEEF;
        for (int c = 0; c < 10; c++) begin
            settle();
            check("hold pkt_v", PW'(pkt_v_o[0]), PW'(1));
            check("hold pkt_data", pkt_data_o[0], exp_pkt);
            check("hold host_ready", PW'(host_ready_o[0]), PW'(0));
            tick();
        end
        host_v_i[0]    = 1'b0;
        pkt_ready_i[0] = 1'b1;
        tick();
        pkt_ready_i[0] = 1'b0;
        settle();
        check("after send pkt_v", PW'(pkt_v_o[0]), PW'(0));
        check("after send host_ready", PW'(host_ready_o[0]), PW'(1));

        // RX fill to full, then final-word dequeue alongside a new packet.
        do_reset();
        for (int i = 0; i < ELS; i++) begin
            pkt_v_i[0]    = 1'b1;
            pkt_data_i[0] = rx_pkt(i);
            settle();
            check("fill pkt_ready", PW'(pkt_ready_o[0]), PW'(1));
            check("fill vacancy", PW'(rcv_vacancy_o[0]), PW'(ELS - i));
            tick();
        end
        pkt_v_i[0] = 1'b0;
        settle();
        check("full vacancy", PW'(rcv_vacancy_o[0]), PW'(0));
        check("full pkt_ready", PW'(pkt_ready_o[0]), PW'(0));
        check("full host_v", PW'(host_v_o[0]), PW'(1));
        for (int k = 0; k < WPP - 1; k++) begin
            host_yumi_i[0] = 1'b1;
            settle();
            check("full head word", PW'(host_data_o[0]), PW'(word_of(rx_pkt(0), k)));
            tick();
        end
        host_yumi_i[0] = 1'b1;
        pkt_v_i[0]     = 1'b1;
        pkt_data_i[0]  = rx_pkt(99);
        settle();
        check("full deq pkt_ready", PW'(pkt_ready_o[0]), PW'(0));
        check("full deq last word", PW'(host_data_o[0]), PW'(word_of(rx_pkt(0), WPP - 1)));
        tick();
        host_yumi_i[0] = 1'b0;
        pkt_v_i[0]     = 1'b0;
        settle();
        check("post deq vacancy", PW'(rcv_vacancy_o[0]), PW'(1));
        check("post deq pkt_ready", PW'(pkt_ready_o[0]), PW'(1));
        for (int p = 1; p < ELS; p++) begin
            for (int k = 0; k < WPP; k++) begin
                host_yumi_i[0] = 1'b1;
                settle();
                check("drain word", PW'(host_data_o[0]), PW'(word_of(rx_pkt(p), k)));
                tick();
            end
        end
        host_yumi_i[0] = 1'b0;
        settle();
        check("drained host_v", PW'(host_v_o[0]), PW'(0));
        check("drained vacancy", PW'(rcv_vacancy_o[0]), PW'(ELS));

        // Flush on slot 0 mid-assembly while slot 1 keeps assembling.
        do_reset();
        host_v_i       = 2'b11;
        host_data_i[0] = 32'h0A0A_0001;
        host_data_i[1] = 32'h5100_0000;
        pkt_v_i[0]     = 1'b1;
        pkt_data_i[0]  = rx_pkt(7);
        tick();
        pkt_v_i[0]     = 1'b0;
        host_data_i[0] = 32'h0A0A_0002;
        host_data_i[1] = 32'h5100_0001;
        tick();
        flush_i[0]     = 1'b1;
        host_data_i[0] = 32'h0A0A_0003;
        host_data_i[1] = 32'h5100_0002;
        settle();
        check("flush host_ready0", PW'(host_ready_o[0]), PW'(0));
        check("flush host_ready1", PW'(host_ready_o[1]), PW'(1));
        check("flush pkt_ready0", PW'(pkt_ready_o[0]), PW'(0));
        tick();
        flush_i[0]     = 1'b0;
        host_v_i[0]    = 1'b0;
        host_data_i[1] = 32'h5100_0003;
        settle();
        check("post flush pkt_v0", PW'(pkt_v_o[0]), PW'(0));
        check("post flush host_v0", PW'(host_v_o[0]), PW'(0));
        check("post flush vacancy0", PW'(rcv_vacancy_o[0]), PW'(ELS));
        check("post flush host_ready0", PW'(host_ready_o[0]), PW'(1));
        tick();
        host_v_i[1] = 1'b0;
        settle();
        check("slot1 pkt_v", PW'(pkt_v_o[1]), PW'(1));
        check("slot1 pkt_data", pkt_data_o[1], 128'h51000003_51000002_51000001_51000000);
        for (int k = 0; k < WPP; k++) begin
            host_v_i[0]    = 1'b1;
            host_data_i[0] = 32'h0D0D_0000 + 32'(k);
            tick();
        end
        host_v_i[0] = 1'b0;
        settle();
        check("refill pkt_v0", PW'(pkt_v_o[0]), PW'(1));
        check("refill pkt_data0", pkt_data_o[0], 128'h0D0D0003_0D0D0002_0D0D0001_0D0D0000);

        // Reset pulse mid-serialization (w = 2) with a partial TX on slot 1.
        do_reset();
        pkt_v_i[0]     = 1'b1;
        pkt_data_i[0]  = rx_pkt(5);
        host_v_i[1]    = 1'b1;
        host_data_i[1] = 32'hFFFF_0000;
        tick();
        pkt_v_i[0] = 1'b0;
        tick();
        host_v_i[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            host_yumi_i[0] = 1'b1;
            settle();
            check("pre reset word", PW'(host_data_o[0]), PW'(word_of(rx_pkt(5), k)));
            tick();
        end
        idle_inputs();
        reset_i = 1'b1;
        settle();
        check_reset_outputs("during reset");
        tick();
        reset_i = 1'b0;
        model_clear();
        settle();
        check_reset_outputs("after reset");
        for (int k = 0; k < WPP; k++) begin
            host_v_i[1]    = 1'b1;
            host_data_i[1] = 32'h7700_0000 + 32'(k);
            tick();
        end
        host_v_i[1] = 1'b0;
        settle();
        check("post reset pkt_data1", pkt_data_o[1], 128'h77000003_77000002_77000001_77000000);

        // Randomized traffic on both slots.
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) rand_cycle(cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
